// File: rtl/mpp_pkg.sv
// Shared definitions for the mpp core and its program-fetch front end.
//   MPP_ADDR_W      : program address width
//   MPP_DATA_W      : instruction byte width
//   MPP_PROG_RD_BIT : bit of the core's out_signals bus carrying the program-read strobe
//   fetch_state_t   : states of the program-memory fetch FSM
package mpp_pkg;

  localparam int MPP_ADDR_W      = 16;
  localparam int MPP_DATA_W      = 8;
  localparam int MPP_PROG_RD_BIT = 1;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_DISCARD
  } fetch_state_t;

endpackage

// File: rtl/mpp_fetch_fifo.sv
// Circular byte buffer holding prefetched instruction bytes.
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data at the tail
//   push_data  : byte to store
//   pop        : drop the head entry
//   flush      : empty the buffer; dominates push and pop
//   head_data  : oldest stored byte
//   count      : number of valid entries
// Simultaneous push and pop leave count unchanged. The caller never
// pushes when full or pops when empty.
module mpp_fetch_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [DATA_W-1:0]          head_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] store [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Byte storage carries no reset; occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) store[wr_ptr] <= push_data;
  end

  assign head_data = store[rd_ptr];

endmodule

// File: rtl/mpp_prog_fetch.sv
// Program-memory fetch stage in front of the mpp core's instruction input.
// Prefetches sequential bytes from a handshaked program memory into a small
// buffer so straight-line code is served one cycle after the request; any
// request that does not match the buffer head flushes and refetches.
//   clk, rst    : clock, synchronous active-high reset
//   core_rd     : core read request, held until core_ready
//   core_addr   : byte address requested by the core
//   core_instr  : returned byte, valid with core_ready, held otherwise
//   core_ready  : one-cycle pulse completing the core request
//   mem_req     : program memory request, held until mem_ack
//   mem_addr    : program memory address
//   mem_ack     : one-cycle acknowledge, mem_data valid in the same cycle
//   mem_data    : program memory read data
//   buf_count   : bytes currently in the prefetch buffer
module mpp_prog_fetch
  import mpp_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = MPP_ADDR_W,
  parameter int DATA_W = MPP_DATA_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    core_rd,
  input  logic [ADDR_W-1:0]       core_addr,
  output logic [DATA_W-1:0]       core_instr,
  output logic                    core_ready,
  output logic                    mem_req,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic                    mem_ack,
  input  logic [DATA_W-1:0]       mem_data,
  output logic [$clog2(DEPTH):0]  buf_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  fetch_state_t      state;
  // head_addr: address of the oldest buffered byte.
  // fetch_addr: address of the byte after the last buffered one; while a
  // live request is out it equals mem_addr and advances on the acknowledge.
  logic [ADDR_W-1:0] head_addr;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] fetch_next;
  logic [DATA_W-1:0] head_data;
  logic              rd_active;
  logic              hit;
  logic              miss;
  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  count_after;

  mpp_fetch_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (mem_data),
    .pop       (pop),
    .flush     (miss),
    .head_data (head_data),
    .count     (buf_count)
  );

  always_comb begin
    // The request is ignored in the cycle it is being answered.
    rd_active  = core_rd && !core_ready;
    hit        = rd_active && (buf_count != '0) && (core_addr == head_addr);
    // An empty buffer waiting on fetch_addr is a pending fill, not a miss.
    miss       = rd_active && ((buf_count == '0) ? (core_addr != fetch_addr)
                                                 : (core_addr != head_addr));
    // Data for a request made stale by this cycle's flush is dropped.
    push       = (state == FETCH_REQ) && mem_ack && !miss;
    pop        = hit;
    fetch_next = fetch_addr + ADDR_W'(1);
    count_after = buf_count;
    if (push && !pop)      count_after = buf_count + CNT_W'(1);
    else if (pop && !push) count_after = buf_count - CNT_W'(1);
  end

  // Core response, address tracking and fetch FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      core_ready <= 1'b0;
      core_instr <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      head_addr  <= '0;
      fetch_addr <= '0;
      state      <= FETCH_IDLE;
    end else begin
      core_ready <= hit;
      if (hit) core_instr <= head_data;

      if (miss) begin
        head_addr  <= core_addr;
        fetch_addr <= core_addr;
      end else begin
        if (pop)  head_addr  <= head_addr + ADDR_W'(1);
        if (push) fetch_addr <= fetch_next;
      end

      case (state)
        FETCH_IDLE: begin
          // After a flush, wait one cycle so the new fetch_addr is issued.
          if (!miss && (count_after < FULL)) begin
            state    <= FETCH_REQ;
            mem_req  <= 1'b1;
            mem_addr <= fetch_addr;
          end
        end
        FETCH_REQ: begin
          if (mem_ack) begin
            if (!miss && (count_after < FULL)) begin
              // Back-to-back request for the following byte.
              mem_addr <= fetch_next;
            end else begin
              state   <= FETCH_IDLE;
              mem_req <= 1'b0;
            end
          end else if (miss) begin
            // The request cannot be withdrawn; ride it out and drop its data.
            state <= FETCH_DISCARD;
          end
        end
        FETCH_DISCARD: begin
          if (mem_ack) begin
            state   <= FETCH_IDLE;
            mem_req <= 1'b0;
          end
        end
        default: begin
          state   <= FETCH_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mpp_prog_fetch.sv
// Directed bench for mpp_prog_fetch with a two-cycle-latency program memory.
module tb_mpp_prog_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_rd;
  logic [15:0] core_addr;
  logic [7:0]  core_instr;
  logic        core_ready;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_data;
  logic [2:0]  buf_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  tbl [logic [15:0]];
  logic [15:0] req_log [$];
  int          bufmax;
  int          wcnt;

  mpp_prog_fetch #(.DEPTH(4), .ADDR_W(16), .DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .core_rd    (core_rd),
    .core_addr  (core_addr),
    .core_instr (core_instr),
    .core_ready (core_ready),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data),
    .buf_count  (buf_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(logic [15:0] a);
    if (tbl.exists(a)) return tbl[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  // Program memory: acknowledges the second negedge after a request appears.
  initial begin
    mem_ack  = 1'b0;
    mem_data = 8'h00;
    wcnt     = 0;
    bufmax   = 0;
    forever begin
      @(negedge clk);
      if (int'(buf_count) > bufmax) bufmax = int'(buf_count);
      if (mem_ack) begin
        mem_ack = 1'b0;
        wcnt    = 0;
      end else if (mem_req && !rst) begin
        if (wcnt == 0) req_log.push_back(mem_addr);
        wcnt = wcnt + 1;
        if (wcnt == 2) begin
          mem_ack  = 1'b1;
          mem_data = mem_byte(mem_addr);
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready(output logic [7:0] d, output bit ok);
    ok = 1'b0;
    d  = 8'h00;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (core_ready) begin
        d  = core_instr;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_read(input string tag, input logic [15:0] a, input logic [7:0] exp);
    logic [7:0] d;
    bit ok;
    core_rd   = 1'b1;
    core_addr = a;
    wait_ready(d, ok);
    core_rd = 1'b0;
    if (!ok) chk({tag, "_timeout"}, 32'd0, 32'd1);
    else     chk(tag, {24'd0, d}, {24'd0, exp});
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    core_rd = 1'b0;
    tick();
    tick();
    req_log.delete();
    bufmax = 0;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    bit ok;
    int idx;
    rst       = 1'b1;
    core_rd   = 1'b0;
    core_addr = 16'h0000;
    tbl[16'h0000] = 8'h07;
    tbl[16'h0001] = 8'hC0;
    tbl[16'h0002] = 8'h44;
    tbl[16'h0003] = 8'hC1;
    tbl[16'h0004] = 8'hCB;
    tbl[16'h0010] = 8'h3C;
    tbl[16'h0040] = 8'h9D;
    tbl[16'hFFFE] = 8'hAA;
    tbl[16'hFFFF] = 8'hBB;

    // Reset state
    tick();
    tick();
    chk("rst_ready", {31'd0, core_ready}, 32'd0);
    chk("rst_instr", {24'd0, core_instr}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_count", {29'd0, buf_count}, 32'd0);
    req_log.delete();
    bufmax = 0;
    rst = 1'b0;

    // Straight-line reads from 0x0000
    do_read("seq0", 16'h0000, 8'h07);
    do_read("seq1", 16'h0001, 8'hC0);
    do_read("seq2", 16'h0002, 8'h44);
    do_read("seq3", 16'h0003, 8'hC1);
    do_read("seq4", 16'h0004, 8'hCB);
    tick();
    chk("instr_hold", {24'd0, core_instr}, 32'h0000_00CB);
    chk("ready_pulse", {31'd0, core_ready}, 32'd0);
    for (int i = 0; i < 5; i++)
      chk($sformatf("seq_addr%0d", i), (i < req_log.size()) ? {16'd0, req_log[i]} : 32'hDEAD, i);
    chk("seq_bufmax", {31'd0, (bufmax <= 4)}, 32'd1);

    // Idle prefetch fills the buffer and stops
    do_reset();
    for (int i = 0; i < 20; i++) tick();
    chk("idle_nreq", req_log.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("idle_addr%0d", i), (i < req_log.size()) ? {16'd0, req_log[i]} : 32'hDEAD, i);
    chk("idle_count", {29'd0, buf_count}, 32'd4);
    chk("idle_mem_req", {31'd0, mem_req}, 32'd0);

    // Jump away from a full buffer
    req_log.delete();
    core_rd   = 1'b1;
    core_addr = 16'h0010;
    tick();
    chk("jump_flush_count", {29'd0, buf_count}, 32'd0);
    chk("jump_no_req", {31'd0, mem_req}, 32'd0);
    wait_ready(d, ok);
    core_rd = 1'b0;
    chk("jump_ok", {31'd0, ok}, 32'd1);
    chk("jump_data", {24'd0, d}, 32'h0000_003C);
    chk("jump_addr", (req_log.size() > 0) ? {16'd0, req_log[0]} : 32'hDEAD, 32'h0000_0010);

    // Miss while the request for 0x0002 is outstanding
    do_reset();
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (mem_req && mem_addr == 16'h0002) begin
        ok = 1'b1;
        break;
      end
    end
    chk("stale_seen", {31'd0, ok}, 32'd1);
    core_rd   = 1'b1;
    core_addr = 16'h0040;
    tick();
    chk("stale_req_held", {31'd0, mem_req}, 32'd1);
    chk("stale_addr_held", {16'd0, mem_addr}, 32'h0000_0002);
    chk("stale_count", {29'd0, buf_count}, 32'd0);
    wait_ready(d, ok);
    core_rd = 1'b0;
    chk("stale_ok", {31'd0, ok}, 32'd1);
    chk("stale_data", {24'd0, d}, 32'h0000_009D);
    chk("stale_log2", (req_log.size() > 2) ? {16'd0, req_log[2]} : 32'hDEAD, 32'h0000_0002);
    chk("stale_log3", (req_log.size() > 3) ? {16'd0, req_log[3]} : 32'hDEAD, 32'h0000_0040);

    // Address wrap-around
    tbl[16'h0000] = 8'h11;
    req_log.delete();
    do_read("wrap0", 16'hFFFE, 8'hAA);
    do_read("wrap1", 16'hFFFF, 8'hBB);
    do_read("wrap2", 16'h0000, 8'h11);
    idx = -1;
    for (int i = 0; i < req_log.size(); i++)
      if (req_log[i] == 16'hFFFF && idx < 0) idx = i;
    chk("wrap_next_addr", (idx >= 0 && idx + 1 < req_log.size()) ? {16'd0, req_log[idx+1]} : 32'hDEAD,
        32'd0);

    // Reset while a request is outstanding
    do_reset();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_req) begin
        ok = 1'b1;
        break;
      end
    end
    chk("midrst_req_seen", {31'd0, ok}, 32'd1);
    rst = 1'b1;
    tick();
    chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("midrst_ready", {31'd0, core_ready}, 32'd0);
    chk("midrst_count", {29'd0, buf_count}, 32'd0);
    chk("midrst_mem_addr", {16'd0, mem_addr}, 32'd0);
    req_log.delete();
    rst = 1'b0;
    do_read("midrst_read", 16'h0000, 8'h11);
    chk("midrst_first_addr", (req_log.size() > 0) ? {16'd0, req_log[0]} : 32'hDEAD, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
